// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first, repeated
// reps+1 times with a one-cycle idle gap between repetitions.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int RPT_W = 4,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] reps,
    input  logic             abort,
    output logic             x_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [RPT_W-1:0] rep_q, rep_d;
    logic             err_q, err_d;
    logic             len_ok;
    logic [LEN_W-1:0] shamt;

    assign len_ok = (len != '0) && (len <= LEN_W'(WIDTH));
    // Pattern is left-aligned at capture so the next bit is always the MSB.
    assign shamt  = LEN_W'(WIDTH) - len;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        pat_d   = pattern << shamt;
                        sh_d    = pattern << shamt;
                        len_d   = len;
                        idx_d   = len - LEN_W'(1);
                        rep_d   = reps;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sh_d = {sh_q[WIDTH-2:0], 1'b0};
                    if (idx_q == '0) begin
                        state_d = (rep_q != '0) ? GAP : DONE;
                    end else begin
                        idx_d = idx_q - LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rep_d   = rep_q - RPT_W'(1);
                    idx_d   = len_q - LEN_W'(1);
                    sh_d    = pat_q;
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
        end
    end

    assign x_out = (state_q == SHIFT) && sh_q[WIDTH-1];
    assign valid = (state_q == SHIFT);
    assign busy  = (state_q == SHIFT) || (state_q == GAP);
    assign done  = (state_q == DONE);
    assign err   = err_q;

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: the stimulus end of the team's serial sequence-detector FSMs. On a start request it captures an up-to-WIDTH-bit pattern, a length and a repeat count, then drives the pattern MSB-first onto a one-bit serial line, one bit per clock. A one-cycle idle gap separates repetitions so a downstream detector returns to its reset state. It replaces hand-written fork/join stimulus with a reusable, cycle-exact source for detector benches and on-chip self-test.

## Interface
- WIDTH, 8, maximum pattern length in bits (≥2)
- RPT_W, 4, width of repeat-count input
- LEN_W, $clog2(WIDTH+1), width of length input (derived)

- clock  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; one clock domain, reset sampled on rising edge of clock
- start  input  1  request, sampled only in IDLE
- pattern  input  WIDTH  bits to send; bit len-1 first, bit 0 last
- len  input  LEN_W  number of bits per transmission, legal 1..WIDTH
- reps  input  RPT_W  extra repetitions; total transmissions = reps+1
- abort  input  1  terminate current transfer
- x_out  output  1  serial data; 0 whenever valid=0
- valid  output  1  x_out carries a pattern bit this cycle
- busy  output  1  transfer in progress (SHIFT or GAP)
- done  output  1  one-cycle pulse after final bit of final repetition
- err  output  1  one-cycle pulse: start with illegal len

## Operation
- All outputs registered (Moore); decoded from state and shift register only.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: start=1 and 1≤len≤WIDTH → capture pattern, len, reps into internal registers; bit index = len-1; go SHIFT. start=1 with len=0 or len>WIDTH → stay IDLE, err=1 next cycle. Otherwise stay.
- SHIFT: x_out = captured pattern[index], valid=1, busy=1. index=0 → go GAP if remaining reps>0, else DONE; otherwise index decrements.
- GAP: x_out=0, valid=0, busy=1 for exactly one cycle; decrement remaining reps; index reloads len-1; go SHIFT.
- DONE: done=1, busy=0, valid=0 for one cycle; go IDLE.
- abort=1 in SHIFT or GAP: next state IDLE; no done pulse; x_out/valid/busy 0 next cycle. abort ignored in IDLE and DONE.
- start outside IDLE ignored (no queueing, no err). start in DONE ignored.
- Inputs pattern/len/reps may change after capture without effect.
- Repeat counter is RPT_W bits, counts down, never wraps: reps=2^RPT_W-1 gives 2^RPT_W transmissions.

## Timing
- Reset: state IDLE; x_out=0, valid=0, busy=0, done=0, err=0; internal registers cleared. Reset has priority over start and abort; reset asserted mid-transfer returns all outputs to 0 on that edge, no done.
- Start sampled on edge k → first bit on x_out during cycle k+1 (latency 1).
- One repetition occupies len SHIFT cycles; repetitions separated by exactly 1 GAP cycle.
- Total busy cycles = (reps+1)·len + reps; done high in cycle k+1+(reps+1)·len+reps.
- Earliest next accepted start: cycle after done (IDLE); back-to-back throughput one transfer per busy+2 cycles.
- err asserted in cycle k+1 for illegal start on edge k; state stays IDLE.
- abort sampled on edge j → outputs idle in cycle j+1.

## Test plan
- Reset then start, pattern=8'b0000_1011, len=4, reps=0 → x_out 1,0,1,1 on cycles k+1..k+4 with valid=1, done=1 on k+5, busy low k+5, IDLE k+6.
- pattern=8'b0000_0111, len=3, reps=2 → x_out 1,1,1,0(gap,valid=0),1,1,1,0(gap),1,1,1; done at k+12; busy=1 exactly 11 cycles; gap cycles force a connected state_diagram detector back to S0.
- Full width: pattern=8'hA5, len=8, reps=0 → 1,0,1,0,0,1,0,1 then done; len=1, pattern bit0=1 → single 1, done at k+2.
- Illegal: len=0 and len=9 with start → err pulse at k+1, busy/valid stay 0, no done; following legal start accepted normally.
- abort at 3rd bit of len=8 transfer → valid/busy/x_out 0 next cycle, no done; start while busy (pattern changed) ignored and not transmitted.
- reset asserted mid-GAP of reps=3 transfer → all outputs 0 on that edge; new start afterwards transmits from fresh capture.
